// File: rtl/sram_ctrl.sv
// Host-to-SRAM initiator: sequences cs/wr/rd strobes through programmable
// setup, pulse and hold phases and returns one response pulse per transaction.
//
// state  | meaning
// IDLE   | ready for a host request, SRAM deselected
// SETUP  | cs, addr and din stable ahead of the strobe
// ACCESS | wr pulsed high (write) or rd pulled low (read)
// HOLD   | strobe released, cs/addr/din held; rsp_valid on first cycle
module sram_ctrl #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       mem_cs,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       lat_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            mem_cs    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b1;
            mem_addr  <= 8'd0;
            mem_din   <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    mem_cs    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_rd    <= 1'b1;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_write <= req_write;
                        mem_addr  <= req_addr;
                        mem_din   <= req_wdata;
                        mem_cs    <= 1'b1;
                        req_ready <= 1'b0;
                        cnt       <= SETUP_LD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        // rd is active-low, so it follows lat_write directly
                        mem_wr <= lat_write;
                        mem_rd <= lat_write;
                        cnt    <= PULSE_LD;
                        state  <= ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        mem_wr    <= 1'b0;
                        mem_rd    <= 1'b1;
                        rsp_valid <= 1'b1;
                        if (!lat_write) begin
                            rsp_rdata <= mem_dout;
                        end
                        cnt   <= HOLD_LD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    if (cnt == 4'd0) begin
                        mem_cs    <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default-timing instance a with an SRAM model,
// plus a 3/1/2 timing instance b for the stretched-phase read.
module tb_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;

    logic       ready_a, rv_a, cs_a, wr_a, rd_a;
    logic [7:0] rdata_a, addr_a, din_a;
    wire  [7:0] dout_a;
    logic       ready_b, rv_b, cs_b, wr_b, rd_b;
    logic [7:0] rdata_b, addr_b, din_b;
    wire  [7:0] dout_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rdata_a), .mem_cs(cs_a), .mem_wr(wr_a),
        .mem_rd(rd_a), .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a)
    );

    sram_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rdata_b), .mem_cs(cs_b), .mem_wr(wr_b),
        .mem_rd(rd_b), .mem_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b)
    );

    // asynchronous SRAM models: write on wr rising edge, drive only while reading
    always @(posedge wr_a) if (cs_a) mem_a[addr_a] <= din_a;
    always @(posedge wr_b) if (cs_b) mem_b[addr_b] <= din_b;
    assign dout_a = (cs_a && !rd_a) ? mem_a[addr_a] : 8'hzz;
    assign dout_b = (cs_b && !rd_b) ? mem_b[addr_b] : 8'hzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic       prev_cs;
    logic [7:0] prev_addr, prev_din;
    always @(negedge clk) begin
        check("wr/rd overlap", 32'(wr_a & ~rd_a), 32'd0);
        if (prev_cs === 1'b1 && cs_a === 1'b1) begin
            check("addr stable under cs", 32'(addr_a), 32'(prev_addr));
            check("din stable under cs", 32'(din_a), 32'(prev_din));
        end
        prev_cs   <= cs_a;
        prev_addr <= addr_a;
        prev_din  <= din_a;
    end

    // one default-timing transaction on instance a, cycles 1..5 after accept
    task automatic txn_a(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit scramble, input string tag);
        logic [5:1] v_wr, v_rdl, v_rv, v_rdy, v_cs, v_stab;
        logic [7:0] rd_at4, rd_before;
        int t;
        t = 0;
        while (!ready_a && t < 20) begin cyc(); t++; end
        check({tag, " ready"}, 32'(ready_a), 32'd1);
        req_write = wr; req_addr = a; req_wdata = d; valid_a = 1'b1;
        rd_before = rdata_a;
        rd_at4 = 8'd0;
        cyc();
        valid_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            v_wr[k]   = wr_a;
            v_rdl[k]  = ~rd_a;
            v_rv[k]   = rv_a;
            v_rdy[k]  = ready_a;
            v_cs[k]   = cs_a;
            v_stab[k] = (addr_a === a) && (din_a === d);
            if (k == 4) rd_at4 = rdata_a;
            if (scramble) begin
                req_addr = 8'($urandom); req_wdata = 8'($urandom); req_write = 1'($urandom);
            end
            if (k < 5) cyc();
        end
        check({tag, " wr"}, 32'(v_wr), wr ? 32'b00110 : 32'b0);
        check({tag, " rd"}, 32'(v_rdl), wr ? 32'b0 : 32'b00110);
        check({tag, " rsp_valid"}, 32'(v_rv), 32'b01000);
        check({tag, " req_ready"}, 32'(v_rdy), 32'b10000);
        check({tag, " cs"}, 32'(v_cs), 32'b01111);
        check({tag, " addr/din"}, 32'(v_stab), 32'b11111);
        check({tag, " rdata"}, 32'(rd_at4), wr ? 32'(rd_before) : 32'(exp_rd));
    endtask

    initial begin
        logic [6:0] b_rdl, b_rv, b_rdy, b_cs, b_wr;
        logic [7:0] b_rd5, exp_val;
        bit exp_pend;
        int t;

        mem_b[8'h10] = 8'h77;
        cyc();
        check("reset req_ready", 32'(ready_a), 32'd0);
        check("reset rsp_valid", 32'(rv_a), 32'd0);
        check("reset rsp_rdata", 32'(rdata_a), 32'd0);
        check("reset mem_cs", 32'(cs_a), 32'd0);
        check("reset mem_wr", 32'(wr_a), 32'd0);
        check("reset mem_rd", 32'(rd_a), 32'd1);
        check("reset mem_addr", 32'(addr_a), 32'd0);
        check("reset mem_din", 32'(din_a), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("ready after release", 32'(ready_a), 32'd1);

        txn_a(1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, "wr 3C");
        txn_a(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, "rd 3C");

        for (int i = 0; i < 256; i++) txn_a(1'b1, 8'(i), 8'(i) ^ 8'h5A, 8'h00, 1'b0, "fill wr");
        for (int i = 0; i < 256; i++) txn_a(1'b0, 8'(i), 8'h00, 8'(i) ^ 8'h5A, 1'b0, "fill rd");

        txn_a(1'b1, 8'h40, 8'hC3, 8'h00, 1'b1, "scramble wr 40");
        check("idle keeps addr", 32'(addr_a), 32'h40);
        check("idle keeps din", 32'(din_a), 32'hC3);

        // host holds req_valid; alternating write then read of the same word
        exp_pend = 1'b0; exp_val = 8'h00;
        valid_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_write = ~i[0];
            req_addr  = 8'h80 + 8'(i / 2);
            req_wdata = 8'h30 + 8'(i);
            t = 0;
            while (!ready_a && t < 20) begin
                cyc(); t++;
                if (rv_a && exp_pend) begin
                    check("b2b rdata", 32'(rdata_a), 32'(exp_val));
                    exp_pend = 1'b0;
                end
            end
            if (i > 0) check("b2b gap", 32'(t), 32'd4);
            cyc();
            if (i[0]) begin exp_pend = 1'b1; exp_val = 8'h30 + 8'(i) - 8'd1; end
        end
        valid_a = 1'b0;
        t = 0;
        while (exp_pend && t < 10) begin
            cyc(); t++;
            if (rv_a) begin
                check("b2b rdata", 32'(rdata_a), 32'(exp_val));
                exp_pend = 1'b0;
            end
        end
        check("b2b drain", 32'(exp_pend), 32'd0);

        // stretched timing: read 0x10 on instance b
        t = 0;
        while (!ready_b && t < 20) begin cyc(); t++; end
        check("b ready", 32'(ready_b), 32'd1);
        req_write = 1'b0; req_addr = 8'h10; req_wdata = 8'h00; valid_b = 1'b1;
        b_rd5 = 8'h00;
        cyc();
        valid_b = 1'b0;
        for (int k = 0; k < 7; k++) begin
            b_rdl[k] = ~rd_b; b_rv[k] = rv_b; b_rdy[k] = ready_b; b_cs[k] = cs_b; b_wr[k] = wr_b;
            if (k == 4) b_rd5 = rdata_b;
            if (k < 6) cyc();
        end
        check("b rd", 32'(b_rdl), 32'b0001000);
        check("b rsp_valid", 32'(b_rv), 32'b0010000);
        check("b req_ready", 32'(b_rdy), 32'b1000000);
        check("b cs", 32'(b_cs), 32'b0111111);
        check("b wr", 32'(b_wr), 32'b0);
        check("b rdata", 32'(b_rd5), 32'h77);

        // reset in cycle 2 of a write to 0x20
        t = 0;
        while (!ready_a && t < 20) begin cyc(); t++; end
        req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h11; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        cyc();
        check("abort wr active", 32'(wr_a), 32'd1);
        rst_n = 1'b0;
        cyc();
        check("abort cs", 32'(cs_a), 32'd0);
        check("abort wr", 32'(wr_a), 32'd0);
        check("abort rd", 32'(rd_a), 32'd1);
        check("abort rsp_valid", 32'(rv_a), 32'd0);
        check("abort req_ready", 32'(ready_a), 32'd0);
        rst_n = 1'b1;
        cyc();
        check("abort ready back", 32'(ready_a), 32'd1);
        check("abort no rsp", 32'(rv_a), 32'd0);
        txn_a(1'b0, 8'h20, 8'h00, 8'h11, 1'b0, "rd 20 after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous initiator for the 256×8 asynchronous SRAM macro: converts single-cycle host read/write requests (valid/ready) into correctly sequenced `cs`/`wr`/`rd` strobes with programmable setup, pulse and hold phases. It sits between a clocked host (CPU/DMA) and the SRAM pins. Read data returns on a one-cycle response strobe.

## Interface
- `SETUP_CYC`, 1: cycles with addr/data/cs stable before the strobe (1..15)
- `PULSE_CYC`, 2: cycles the `wr` or `rd` strobe is active (1..15)
- `HOLD_CYC`, 1: cycles addr/data/cs held after the strobe ends (1..15)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  host request present
- `req_ready`  out  1  controller idle, accepts request this cycle
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  8  word address
- `req_wdata`  in  8  write data
- `rsp_valid`  out  1  one-cycle pulse: transaction complete
- `rsp_rdata`  out  8  read data, valid with `rsp_valid` on reads
- `mem_cs`  out  1  SRAM chip select, active-high
- `mem_wr`  out  1  SRAM write strobe, active-high (write on rising edge)
- `mem_rd`  out  1  SRAM read enable, active-low
- `mem_addr`  out  8  SRAM address
- `mem_din`  out  8  SRAM write data
- `mem_dout`  in  8  SRAM read data (high-Z when SRAM not reading)

## Operation
- All outputs registered. Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `mem_cs`=0, `mem_wr`=0, `mem_rd`=1, `mem_addr`=0, `mem_din`=0; state IDLE.
- States: IDLE, SETUP, ACCESS, HOLD. A 4-bit phase counter loads N−1 on phase entry and counts down; phase exits when it reaches 0.
- IDLE: `req_ready`=1, `mem_cs`=0, `mem_wr`=0, `mem_rd`=1. On `req_valid && req_ready`: latch `req_write`, `req_addr`, `req_wdata`; next state SETUP; `req_ready` drops the same edge.
- SETUP (SETUP_CYC cycles): `mem_cs`=1, `mem_addr`/`mem_din` = latched values, `mem_wr`=0, `mem_rd`=1. Then ACCESS.
- ACCESS (PULSE_CYC cycles): write: `mem_wr`=1; read: `mem_rd`=0. On the edge ending the last ACCESS cycle of a read, `rsp_rdata` ← `mem_dout`. Then HOLD.
- HOLD (HOLD_CYC cycles): `mem_wr`=0, `mem_rd`=1, `mem_cs`=1, addr/din unchanged. `rsp_valid`=1 during the first HOLD cycle only, for both reads and writes. After the last HOLD cycle: IDLE, `mem_cs`=0.
- Writes leave `rsp_rdata` unchanged.
- `mem_wr` and `mem_rd` never active in the same cycle; `mem_addr`/`mem_din` never change while `mem_cs`=1.
- Host inputs ignored outside the accept cycle; a request presented while busy stays pending (host holds `req_valid`) and is accepted in the next IDLE cycle.
- `mem_addr`/`mem_din` retain the last transaction's values in IDLE.
- `rst_n` low at any edge, including mid-strobe: next cycle all outputs at reset values and state IDLE; the aborted transaction produces no `rsp_valid`. A write aborted during ACCESS has already triggered the SRAM rising edge and is not rolled back.

## Timing
- Accept at edge E0. SETUP occupies cycles 1..S, ACCESS S+1..S+P, HOLD S+P+1..S+P+H (S/P/H = parameters).
- `rsp_valid` high in cycle S+P+1; `rsp_rdata` valid in that cycle and held until the next read completes.
- `req_ready` returns high in cycle S+P+H+1. Back-to-back throughput: one transaction per S+P+H+1 cycles (defaults: 5).
- `mem_rd` low for exactly PULSE_CYC cycles; read data is sampled at least one full cycle after `mem_rd` falls when PULSE_CYC≥1.
- After reset release (first edge with `rst_n`=1), `req_ready` rises one cycle later.

## Test plan
- Defaults. Write addr 0x3C data 0xA5, then read 0x3C: `mem_wr` high exactly cycles 2–3 after accept, `mem_rd` low cycles 2–3 of the read, `rsp_valid` in cycle 4, `rsp_rdata`=0xA5.
- Fill all 256 addresses with data = addr XOR 0x5A, then read back sequentially: every `rsp_rdata` matches; address 0xFF→0x00 wrap handled.
- `req_valid` held continuously with alternating write/read: accepts every 5 cycles, `req_ready` low in between, no `mem_wr`/`mem_rd` overlap, no addr/din change while `mem_cs`=1.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2. Read 0x10 preloaded with 0x77: `mem_rd` low only in cycle 4, `rsp_valid` in cycle 5, `rsp_rdata`=0x77, `req_ready` back in cycle 7.
- `rst_n` pulled low in cycle 2 of a write to 0x20 (data 0x11): next cycle `mem_cs`=0, `mem_wr`=0, `mem_rd`=1, `rsp_valid`=0. After release, a read of 0x20 returns 0x11 (SRAM edge already occurred).
- Change `req_addr`/`req_wdata` every cycle after acceptance of a write 0x40/0xC3: `mem_addr`=0x40 and `mem_din`=0xC3 stable throughout the transaction.
